// File: rtl/dmem_pkg.sv
// Shared definitions for the data-bus responder: MMIO page layout, CON_STAT bit
// positions and the region-select type used by the address decoder.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [7:0] OFF_CON_DATA = 8'h00;
    localparam logic [7:0] OFF_CON_STAT = 8'h04;
    localparam logic [7:0] OFF_MTIME_LO = 8'h08;
    localparam logic [7:0] OFF_MTIME_HI = 8'h0C;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_MMIO,
        SEL_NONE
    } sel_t;

    // RAM takes priority; the MMIO page is matched on the upper 24 address bits.
    function automatic sel_t decode_addr(input logic [31:0] addr,
                                         input logic [32:0] ram_bytes,
                                         input logic [23:0] mmio_page);
        if ({1'b0, addr} < ram_bytes)
            return SEL_RAM;
        else if (addr[31:8] == mmio_page)
            return SEL_MMIO;
        else
            return SEL_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_con_fifo.sv
// Console TX byte FIFO: power-of-two depth, head presented combinationally,
// sticky overflow when a push arrives while full and nothing drains that cycle.
module con_fifo
    import dmem_pkg::*;
#(
    parameter int CON_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [7:0]                   push_data,
    input  logic                         pop,
    input  logic                         ovf_clr,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic [$clog2(CON_DEPTH):0]   count,
    output logic [7:0]                   head
);

    localparam int PW = $clog2(CON_DEPTH);

    logic [7:0]    mem [CON_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   cnt;
    logic          do_pop;
    logic          do_push;

    assign full  = (cnt == (PW + 1)'(CON_DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = empty ? 8'h00 : mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push && !do_push)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // NOTE: storage arrays carry no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-bus responder: byte-writable RAM, console FIFO and optional 64-bit timer
// in one MMIO page. Define DMEM_MTIME_EN to build the mtime counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int          CON_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_r,
    input  logic [3:0]  ram_w,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_out,
    output logic [31:0] ram_in,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        bus_err
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(CON_DEPTH) + 1;
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    sel_t        sel;
    logic [7:0]  off;
    logic [AW-1:0] word_idx;
    logic        mmio_acc;

    assign sel      = decode_addr(ram_addr, RAM_BYTES, MMIO_BASE[31:8]);
    assign off      = {ram_addr[7:2], 2'b00};
    assign word_idx = ram_addr[AW+1:2];
    assign mmio_acc = (sel == SEL_MMIO);

    // ---------------------------------------------------------------- RAM
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (sel == SEL_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_w[i])
                    ram[word_idx][8*i +: 8] <= ram_out[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------- console FIFO
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic [CW-1:0] fifo_count;
    logic          con_push;
    logic          con_pop;
    logic          ovf_clr;

    assign con_push  = mmio_acc && (off == OFF_CON_DATA) && ram_w[0];
    assign ovf_clr   = mmio_acc && (off == OFF_CON_STAT) && ram_w[0] && ram_out[STAT_OVF_BIT];
    assign con_pop   = con_valid & con_ready;
    assign con_valid = ~fifo_empty;

    con_fifo #(
        .CON_DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (con_push),
        .push_data (ram_out[7:0]),
        .pop       (con_pop),
        .ovf_clr   (ovf_clr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf),
        .count     (fifo_count),
        .head      (con_data)
    );

    logic [31:0] con_stat;

    always_comb begin
        con_stat                          = '0;
        con_stat[STAT_FULL_BIT]           = fifo_full;
        con_stat[STAT_EMPTY_BIT]          = fifo_empty;
        con_stat[STAT_OVF_BIT]            = fifo_ovf;
        con_stat[STAT_COUNT_LSB +: 8]     = 8'(fifo_count);
    end

    // -------------------------------------------------------------- mtime
    logic [31:0] mtime_lo_rd;
    logic [31:0] mtime_hi_rd;

`ifdef DMEM_MTIME_EN
    logic [63:0] mtime;
    logic        wr_lo;
    logic        wr_hi;

    assign wr_lo = mmio_acc && (off == OFF_MTIME_LO) && (ram_w == 4'hF);
    assign wr_hi = mmio_acc && (off == OFF_MTIME_HI) && (ram_w == 4'hF);

    // A half-load replaces that cycle's increment for the whole counter.
    always_ff @(posedge clk) begin
        if (rst)
            mtime <= '0;
        else if (wr_lo)
            mtime[31:0] <= ram_out;
        else if (wr_hi)
            mtime[63:32] <= ram_out;
        else
            mtime <= mtime + 64'd1;
    end

    assign mtime_lo_rd = mtime[31:0];
    assign mtime_hi_rd = mtime[63:32];
`else
    assign mtime_lo_rd = '0;
    assign mtime_hi_rd = '0;
`endif

    // ----------------------------------------------------------- read mux
    logic [31:0] rdata;

    // NOTE: every output of this block is assigned up front so no path can
    // leave it holding its previous value (which would infer a latch).
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_RAM:  rdata = ram[word_idx];
            SEL_MMIO: begin
                case (off)
                    OFF_CON_STAT: rdata = con_stat;
                    OFF_MTIME_LO: rdata = mtime_lo_rd;
                    OFF_MTIME_HI: rdata = mtime_hi_rd;
                    default:      rdata = '0;
                endcase
            end
            default:  rdata = '0;
        endcase
    end

    assign ram_in = ram_r ? rdata : 32'h0;

    // ------------------------------------------------------------ bus_err
    always_ff @(posedge clk) begin
        if (rst)
            bus_err <= 1'b0;
        else if ((sel == SEL_NONE) && (ram_r || (ram_w != 4'h0)))
            bus_err <= 1'b1;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal
// expectations plus a randomized phase against a queue/array reference model.
module tb_dmem_responder;

    localparam int          RAM_WORDS = 1024;
    localparam int          CON_DEPTH = 8;
    localparam logic [23:0] MMIO_PAGE = 24'hFFFF00;
    localparam logic [31:0] A_DATA    = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT    = 32'hFFFF_0004;
    localparam logic [31:0] A_MLO     = 32'hFFFF_0008;
    localparam logic [31:0] A_MHI     = 32'hFFFF_000C;

    logic        clk;
    logic        rst;
    logic        ram_r;
    logic [3:0]  ram_w;
    logic [31:0] ram_addr;
    logic [31:0] ram_out;
    logic [31:0] ram_in;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        bus_err;

    dmem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .ram_r     (ram_r),
        .ram_w     (ram_w),
        .ram_addr  (ram_addr),
        .ram_out   (ram_out),
        .ram_in    (ram_in),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    logic [31:0] m_ram [int unsigned];
    logic [7:0]  m_q [$];
    bit          m_ovf;
    bit          m_err;
    logic [63:0] m_mtime;
    bit          started = 0;

    function automatic int region(input logic [31:0] a);
        if (a < 32'(4 * RAM_WORDS)) return 0;
        if (a[31:8] == MMIO_PAGE)   return 1;
        return 2;
    endfunction

    // Expected ram_in for the current inputs; returns 0 when the word is unknown.
    function automatic bit model_read(output logic [31:0] v);
        logic [7:0]  o;
        int unsigned idx;
        v = 32'h0;
        if (!ram_r) return 1;
        o   = {ram_addr[7:2], 2'b00};
        idx = ram_addr[31:2];
        case (region(ram_addr))
            0: begin
                if (!m_ram.exists(idx)) return 0;
                v = m_ram[idx];
            end
            1: begin
                if (o == 8'h04)
                    v = {16'h0, 8'(m_q.size()), 5'b0, m_ovf, m_q.size() == 0, m_q.size() == CON_DEPTH};
`ifdef DMEM_MTIME_EN
                else if (o == 8'h08) v = m_mtime[31:0];
                else if (o == 8'h0C) v = m_mtime[63:32];
`endif
            end
            default: v = 32'h0;
        endcase
        return 1;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ovf   = 0;
            m_err   = 0;
            m_mtime = 64'h0;
            started = 1;
        end else begin
            int          rg;
            logic [7:0]  o;
            int unsigned idx;
            bit          pop;
            bit          was_full;
            rg       = region(ram_addr);
            o        = {ram_addr[7:2], 2'b00};
            idx      = ram_addr[31:2];
            pop      = (m_q.size() > 0) && con_ready;
            was_full = (m_q.size() == CON_DEPTH);
            if (rg == 2 && (ram_r || ram_w != 4'h0)) m_err = 1;
            if (rg == 0) begin
                if (m_ram.exists(idx)) begin
                    for (int i = 0; i < 4; i++)
                        if (ram_w[i]) m_ram[idx][8*i +: 8] = ram_out[8*i +: 8];
                end else if (ram_w == 4'hF) begin
                    m_ram[idx] = ram_out;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (rg == 1 && o == 8'h00 && ram_w[0]) begin
                if (!was_full || pop) m_q.push_back(ram_out[7:0]);
                else m_ovf = 1;
            end
            if (rg == 1 && o == 8'h04 && ram_w[0] && ram_out[2]) m_ovf = 0;
            if (rg == 1 && o == 8'h08 && ram_w == 4'hF)      m_mtime[31:0]  = ram_out;
            else if (rg == 1 && o == 8'h0C && ram_w == 4'hF) m_mtime[63:32] = ram_out;
            else                                             m_mtime        = m_mtime + 64'd1;
        end
    end

    // Every cycle: compare all outputs against the model on the falling edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            logic [31:0] ev;
            if (model_read(ev)) check("ram_in", ram_in, ev);
            check("con_valid", {31'h0, con_valid}, {31'h0, m_q.size() > 0});
            check("con_data", {24'h0, con_data}, {24'h0, (m_q.size() > 0) ? m_q[0] : 8'h00});
            check("bus_err", {31'h0, bus_err}, {31'h0, m_err});
        end
    end

    // -------------------------------------------------------------- driver
    task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        ram_r = r; ram_w = w; ram_addr = a; ram_out = d;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        drive(1'b0, w, a, d);
        step();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 4'h0, a, 32'h0);
        #1 check(name, ram_in, exp);
        step();
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    logic [7:0] t4_exp [8] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h5A};

    initial begin
        rst = 1'b1;
        con_ready = 1'b0;
        idle();
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_con_valid", {31'h0, con_valid}, 32'h0);
        check("rst_con_data", {24'h0, con_data}, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        step();
        rd_chk("rst_stat", A_STAT, 32'h0000_0002);

        // lane writes
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd_chk("t1_full", 32'h10, 32'hDEAD_BEEF);
        wr(32'h10, 32'h0000_5500, 4'b0010);
        rd_chk("t1_lane", 32'h10, 32'hDEAD_55EF);

        // read-during-write
        wr(32'h20, 32'h1, 4'hF);
        drive(1'b1, 4'hF, 32'h20, 32'h2);
        #1 check("t2_old", ram_in, 32'h1);
        step();
        rd_chk("t2_new", 32'h20, 32'h2);

        // last RAM word, low address bits ignored
        wr(32'hFFC, 32'hA5A5_1234, 4'hF);
        rd_chk("ram_top", 32'hFFF, 32'hA5A5_1234);

        // overflow
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'(8'h41 + i), 4'h1);
        idle();
        rd_chk("t3_stat", A_STAT, 32'h0000_0805);
        idle();
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check("t3_drain", {24'h0, con_data}, 32'(8'h41 + i));
            step();
        end
        check("t3_empty", {31'h0, con_valid}, 32'h0);
        rd_chk("t3_ovf_kept", A_STAT, 32'h0000_0006);
        wr(A_STAT, 32'h4, 4'h1);
        rd_chk("t3_ovf_clr", A_STAT, 32'h0000_0002);

        // push and pop together while full
        con_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(A_DATA, 32'(8'h50 + i), 4'h1);
        con_ready = 1'b1;
        wr(A_DATA, 32'h5A, 4'h1);
        con_ready = 1'b0;
        rd_chk("t4_stat", A_STAT, 32'h0000_0801);
        idle();
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check("t4_drain", {24'h0, con_data}, {24'h0, t4_exp[i]});
            step();
        end
        con_ready = 1'b0;

        // mtime carry
        wr(A_MLO, 32'hFFFF_FFFE, 4'hF);
        wr(A_MHI, 32'h0, 4'hF);
`ifdef DMEM_MTIME_EN
        rd_chk("t5_lo", A_MLO, 32'hFFFF_FFFE);
        rd_chk("t5_hi0", A_MHI, 32'h0);
        rd_chk("t5_hi1", A_MHI, 32'h1);
        rd_chk("t5_lo0", A_MLO, 32'h1);
`else
        rd_chk("t5_lo_off", A_MLO, 32'h0);
        rd_chk("t5_hi_off", A_MHI, 32'h0);
`endif
        rd_chk("mmio_unused", 32'hFFFF_0040, 32'h0);
        check("mmio_no_err", {31'h0, bus_err}, 32'h0);

        // bus error, then reset flushes the FIFO
        wr(A_DATA, 32'h77, 4'h1);
        wr(A_DATA, 32'h78, 4'h1);
        rd_chk("t6_rd", 32'h8000_0000, 32'h0);
        check("t6_err", {31'h0, bus_err}, 32'h1);
        idle();
        step(); step();
        check("t6_err_held", {31'h0, bus_err}, 32'h1);
        check("t6_fifo_busy", {31'h0, con_valid}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_err", {31'h0, bus_err}, 32'h0);
        check("t6_rst_fifo", {31'h0, con_valid}, 32'h0);
        wr(32'h1000, 32'h1234, 4'hF);
        check("ram_end_err", {31'h0, bus_err}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // randomized phase
        for (int i = 0; i < 16; i++) wr(32'h100 + 32'(4 * i), $urandom, 4'hF);
        for (int c = 0; c < 3000; c++) begin
            int k;
            logic [31:0] wa;
            k  = $urandom_range(0, 199);
            wa = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if (c % 40 == 0) con_ready = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 7) == 0) con_ready = ~con_ready;
            rst = 1'b0;
            if (k < 60)       drive($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)), wa, $urandom);
            else if (k < 110) drive(1'b1, 4'h0, wa, 32'h0);
            else if (k < 140) drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)) | 4'h1, A_DATA | 32'($urandom_range(0, 3)), $urandom);
            else if (k < 150) drive(1'b1, 4'h0, A_STAT, 32'h0);
            else if (k < 155) drive(1'b0, 4'($urandom_range(0, 15)), A_STAT, $urandom);
            else if (k < 165) drive(1'b1, 4'h0, ($urandom_range(0, 1) == 1) ? A_MHI : A_MLO, 32'h0);
            else if (k < 170) drive(1'b0, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                                    ($urandom_range(0, 1) == 1) ? A_MHI : A_MLO, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            else if (k < 185) drive($urandom_range(0, 1) == 1, 4'($urandom), 32'hFFFF_0010 + 32'($urandom_range(0, 239)), $urandom);
            else if (k < 187) drive($urandom_range(0, 1) == 1, 4'($urandom), 32'h0001_0000 + $urandom_range(0, 32'hFFFF), $urandom);
            else if (k < 189) begin idle(); rst = 1'b1; end
            else idle();
            step();
        end
        idle();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
